tsg: RTL and testbench

//  TS generator: transmit side of the LTSSM training-set path, peer of the TS analyzer.

---
 rtl/tsg_pkg.sv | 94 +++++++++
 rtl/tsg.sv | 181 ++++++++++++++++++
 tb/tb_tsg.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsg_pkg.sv
// tsg_pkg: shared training-set constants, LTSSM state/substate codes and the
// combinational TS symbol builder used by the TS generator.
`timescale 1ns/1ps
package tsg_pkg;

  localparam int unsigned SYM_W   = 8;
  localparam int unsigned NUM_SYM = 16;
  localparam int unsigned TS_W    = SYM_W * NUM_SYM;
  localparam int unsigned INFO_W  = 8;
  localparam int unsigned LANE_W  = 4;
  localparam int unsigned RATE_W  = 6;
  localparam int unsigned CODE_W  = 4;

  // Symbol values
  localparam logic [SYM_W-1:0]  COM          = 8'hBC;
  localparam logic [SYM_W-1:0]  PADG12       = 8'hF7;
  localparam logic [SYM_W-1:0]  TS1_IDTFR    = 8'h4A;
  localparam logic [SYM_W-1:0]  TS2_IDTFR    = 8'h45;
  localparam logic [SYM_W-1:0]  LINK_NUM     = 8'h01;
  localparam logic [RATE_W-1:0] RATE_SUPPORT = 6'h02;

  // LTSSM major states
  localparam logic [CODE_W-1:0] LTSSM_POLL = 4'h2;
  localparam logic [CODE_W-1:0] LTSSM_CFG  = 4'h3;

  // Polling substates
  localparam logic [CODE_W-1:0] POLL_ACTIVE = 4'h0;
  localparam logic [CODE_W-1:0] POLL_CONFIG = 4'h1;

  // Configuration substates
  localparam logic [CODE_W-1:0] CFG_LW_START = 4'h0;
  localparam logic [CODE_W-1:0] CFG_LW_ACC   = 4'h1;
  localparam logic [CODE_W-1:0] CFG_LN_WAIT  = 4'h2;
  localparam logic [CODE_W-1:0] CFG_LN_ACC   = 4'h3;
  localparam logic [CODE_W-1:0] CFG_COMPLETE = 4'h4;
  localparam logic [CODE_W-1:0] CFG_IDLE     = 4'h5;

  // Port role
  localparam logic MODE_DSP = 1'b0;
  localparam logic MODE_USP = 1'b1;

  // Index 0 is the first symbol on the wire and lands in bits [127:120]
  typedef logic [0:NUM_SYM-1][SYM_W-1:0] ts_sym_t;

  typedef struct packed {
    logic [CODE_W-1:0] ltssm;
    logic [CODE_W-1:0] sub;
  } ts_info_t;

  typedef enum logic {
    TSG_IDLE = 1'b0,
    TSG_SEND = 1'b1
  } tsg_state_e;

  // Only Polling and Configuration produce training sets
  function automatic logic is_handled(input ts_info_t info);
    return (info.ltssm == LTSSM_POLL) || (info.ltssm == LTSSM_CFG);
  endfunction

  function automatic logic is_poll_active(input ts_info_t info);
    return (info.ltssm == LTSSM_POLL) && (info.sub == POLL_ACTIVE);
  endfunction

  // Freshly loaded TS content; upstream link/lane echo starts as PAD and is
  // filled in later by capture while sending.
  function automatic ts_sym_t build_ts(input ts_info_t          info,
                                       input logic              mode,
                                       input logic [LANE_W-1:0] lane_num);
    ts_sym_t ts;
    ts    = '0;
    ts[0] = COM;
    ts[1] = PADG12;
    ts[2] = PADG12;
    ts[3] = 8'hFF;
    ts[4] = SYM_W'({2'b00, RATE_SUPPORT});
    ts[5] = 8'h00;
    for (int i = 6; i < int'(NUM_SYM); i++) ts[i] = TS1_IDTFR;
    if (info.ltssm == LTSSM_POLL) begin
      if (info.sub != POLL_ACTIVE) begin
        for (int i = 6; i < int'(NUM_SYM); i++) ts[i] = TS2_IDTFR;
      end
    end else if (info.ltssm == LTSSM_CFG) begin
      if (info.sub == CFG_COMPLETE) begin
        for (int i = 6; i < int'(NUM_SYM); i++) ts[i] = TS2_IDTFR;
      end
      if (mode == MODE_DSP) begin
        ts[1] = LINK_NUM;
        if (info.sub != CFG_LW_START) ts[2] = SYM_W'({4'h0, lane_num});
      end
    end
    return ts;
  endfunction

endpackage

// File: rtl/tsg.sv
// tsg: TS generator, transmit side of the LTSSM training-set path.
// Builds the TS1/TS2 for the current state/substate, emits one every TS_PERIOD
// cycles, counts them and flags when enough have been sent. Upstream ports
// fold link/lane numbers received by the analyzer into later TSs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ts_info/ts_update        FSM load request ([7:4] state, [3:0] substate), held until ack
//   ts_update_ack            1-cycle ack of a load request
//   ts_stop                  stop emission, back to IDLE
//   mode, lane_num           DSP/USP role, local lane number
//   rcv_link_num(_vld)       link number seen by the analyzer
//   rcv_lane_num(_vld)       lane number seen by the analyzer
//   tsg_update_ack           1-cycle pulse after a received number is captured
//   ts_sent_enough           sent count reached the substate target (level)
//   local_ts_valid/local_ts  TS strobe and 128-bit TS, symbol 0 in [127:120]
`timescale 1ns/1ps
module tsg
  import tsg_pkg::*;
#(
  parameter int unsigned TS_PERIOD       = 16,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned TX_NUM_POLL_ACT = 1024,
  parameter int unsigned TX_NUM_GENERAL  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INFO_W-1:0] ts_info,
  input  logic              ts_update,
  output logic              ts_update_ack,
  input  logic              ts_stop,
  input  logic              mode,
  input  logic [LANE_W-1:0] lane_num,
  input  logic [SYM_W-1:0]  rcv_link_num,
  input  logic              rcv_link_num_vld,
  input  logic [SYM_W-1:0]  rcv_lane_num,
  input  logic              rcv_lane_num_vld,
  output logic              tsg_update_ack,
  output logic              ts_sent_enough,
  output logic              local_ts_valid,
  output logic [TS_W-1:0]   local_ts
);

  localparam int unsigned PER_W = (TS_PERIOD > 1) ? $clog2(TS_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST    = PER_W'(TS_PERIOD - 1);
  localparam logic [CNT_W-1:0] TGT_POLL    = CNT_W'(TX_NUM_POLL_ACT);
  localparam logic [CNT_W-1:0] TGT_GENERAL = CNT_W'(TX_NUM_GENERAL);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  tsg_state_e       state_q, state_d;
  ts_info_t         info_q, info_d;
  ts_sym_t          sym_q, sym_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             enough_q, enough_d;
  logic             ack_q, ack_d;
  logic             tsg_ack_q, tsg_ack_d;
  logic             vld_q, vld_d;
  logic [TS_W-1:0]  ts_q, ts_d;

  ts_info_t         req_info;
  logic             new_req;
  logic [CNT_W-1:0] target;
  logic             usp_cfg;

  // A held ts_update is only a new request once the previous ack has dropped
  assign req_info = ts_info_t'(ts_info);
  assign new_req  = ts_update && !ack_q;
  assign target   = is_poll_active(info_q) ? TGT_POLL : TGT_GENERAL;
  assign usp_cfg  = (info_q.ltssm == LTSSM_CFG) && (mode == MODE_USP);

  // Next-state, counters, symbol capture and output strobes
  always_comb begin
    state_d   = state_q;
    info_d    = info_q;
    sym_d     = sym_q;
    per_d     = per_q;
    sent_d    = sent_q;
    enough_d  = enough_q;
    ack_d     = 1'b0;
    tsg_ack_d = 1'b0;
    vld_d     = 1'b0;
    ts_d      = ts_q;

    unique case (state_q)
      TSG_IDLE: begin
        per_d    = '0;
        sent_d   = '0;
        enough_d = 1'b0;
        if (new_req) begin
          ack_d = 1'b1;
          if (is_handled(req_info)) begin
            info_d  = req_info;
            sym_d   = build_ts(req_info, mode, lane_num);
            state_d = TSG_SEND;
          end
        end
      end

      TSG_SEND: begin
        if (ts_stop) begin
          // Stop wins over a simultaneous update, which stays pending for IDLE
          state_d  = TSG_IDLE;
          per_d    = '0;
          sent_d   = '0;
          enough_d = 1'b0;
        end else if (new_req) begin
          ack_d    = 1'b1;
          per_d    = '0;
          sent_d   = '0;
          enough_d = 1'b0;
          if (is_handled(req_info)) begin
            info_d = req_info;
            sym_d  = build_ts(req_info, mode, lane_num);
          end else begin
            state_d = TSG_IDLE;
          end
        end else begin
          if (per_q == PER_LAST) begin
            per_d = '0;
            vld_d = 1'b1;
            ts_d  = TS_W'(sym_q);
            if (sent_q != CNT_MAX) sent_d = sent_q + CNT_W'(1);
          end else begin
            per_d = per_q + PER_W'(1);
          end
          // Registered from the count, so it rises one cycle after the strobe
          enough_d = (sent_q >= target);
          // Captures land in the symbol regs; the strobe above already took
          // the old copy, so a change only shows from the next TS.
          if (usp_cfg) begin
            if (rcv_link_num_vld && (rcv_link_num != sym_q[1])) begin
              sym_d[1]  = rcv_link_num;
              tsg_ack_d = 1'b1;
            end
            if ((info_q.sub != CFG_LW_START) && rcv_lane_num_vld &&
                (rcv_lane_num != sym_q[2])) begin
              sym_d[2]  = rcv_lane_num;
              tsg_ack_d = 1'b1;
            end
          end
        end
      end

      default: state_d = TSG_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TSG_IDLE;
      info_q    <= '0;
      sym_q     <= '0;
      per_q     <= '0;
      sent_q    <= '0;
      enough_q  <= 1'b0;
      ack_q     <= 1'b0;
      tsg_ack_q <= 1'b0;
      vld_q     <= 1'b0;
      ts_q      <= '0;
    end else begin
      state_q   <= state_d;
      info_q    <= info_d;
      sym_q     <= sym_d;
      per_q     <= per_d;
      sent_q    <= sent_d;
      enough_q  <= enough_d;
      ack_q     <= ack_d;
      tsg_ack_q <= tsg_ack_d;
      vld_q     <= vld_d;
      ts_q      <= ts_d;
    end
  end

  assign ts_update_ack  = ack_q;
  assign tsg_update_ack = tsg_ack_q;
  assign ts_sent_enough = enough_q;
  assign local_ts_valid = vld_q;
  assign local_ts       = ts_q;

endmodule

// File: tb/tb_tsg.sv
// tb_tsg: randomized scoreboard bench for the TS generator.
`timescale 1ns/1ps
module tb_tsg;
  import tsg_pkg::*;

  localparam int P       = 16;
  localparam int TGT_PA  = 1024;
  localparam int TGT_GEN = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   ts_info = '0;
  logic         ts_update = 1'b0;
  logic         ts_update_ack;
  logic         ts_stop = 1'b0;
  logic         mode = 1'b0;
  logic [3:0]   lane_num = '0;
  logic [7:0]   rcv_link_num = '0;
  logic         rcv_link_num_vld = 1'b0;
  logic [7:0]   rcv_lane_num = '0;
  logic         rcv_lane_num_vld = 1'b0;
  logic         tsg_update_ack;
  logic         ts_sent_enough;
  logic         local_ts_valid;
  logic [127:0] local_ts;

  tsg #(.TS_PERIOD(P), .CNT_W(16), .TX_NUM_POLL_ACT(TGT_PA), .TX_NUM_GENERAL(TGT_GEN)) dut (
    .clk(clk), .rst(rst), .ts_info(ts_info), .ts_update(ts_update),
    .ts_update_ack(ts_update_ack), .ts_stop(ts_stop), .mode(mode), .lane_num(lane_num),
    .rcv_link_num(rcv_link_num), .rcv_link_num_vld(rcv_link_num_vld),
    .rcv_lane_num(rcv_lane_num), .rcv_lane_num_vld(rcv_lane_num_vld),
    .tsg_update_ack(tsg_update_ack), .ts_sent_enough(ts_sent_enough),
    .local_ts_valid(local_ts_valid), .local_ts(local_ts)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int cyc; logic [127:0] ts; } exp_ts_t;
  exp_ts_t exp_ts_q[$];
  int      exp_ack_q[$];
  int      exp_tsg_q[$];
  logic    exp_enough = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected TS straight from the content rules, literal symbol values
  function automatic logic [127:0] ref_ts(input logic [7:0] info, input logic md,
                                          input logic [3:0] ln, input logic have_lk,
                                          input logic [7:0] lk, input logic have_ln,
                                          input logic [7:0] rl);
    logic [7:0] s1, s2, id;
    s1 = 8'hF7;
    s2 = 8'hF7;
    if (info[7:4] == LTSSM_POLL) begin
      id = (info[3:0] == POLL_ACTIVE) ? 8'h4A : 8'h45;
    end else begin
      id = (info[3:0] == CFG_COMPLETE) ? 8'h45 : 8'h4A;
      if (md == MODE_DSP) begin
        s1 = 8'h01;
        if (info[3:0] != CFG_LW_START) s2 = {4'h0, ln};
      end else begin
        if (have_lk) s1 = lk;
        if (info[3:0] != CFG_LW_START && have_ln) s2 = rl;
      end
    end
    return {8'hBC, s1, s2, 8'hFF, 8'h02, 8'h00, {10{id}}};
  endfunction

  // Reference model: transaction-level view sampled at each rising edge
  initial begin : model
    bit         active;
    int         load_cyc, last_ack, tgt;
    logic [7:0] m_info;
    logic       m_mode;
    logic [3:0] m_lane;
    bit         have_lk, have_ln;
    logic [7:0] lk, rl;
    logic [7:0] cur_s1, cur_s2;
    active = 0; load_cyc = 0; last_ack = -10; tgt = 0; m_info = '0; m_mode = 0; m_lane = '0;
    have_lk = 0; have_ln = 0; lk = '0; rl = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        active = 0;
        last_ack = -10;
        exp_ts_q.delete();
        exp_ack_q.delete();
        exp_tsg_q.delete();
      end else if (active && ts_stop) begin
        active = 0;
      end else if (ts_update && last_ack != cyc - 1) begin
        exp_ack_q.push_back(cyc);
        last_ack = cyc;
        active = (ts_info[7:4] == LTSSM_POLL) || (ts_info[7:4] == LTSSM_CFG);
        if (active) begin
          load_cyc = cyc;
          m_info = ts_info; m_mode = mode; m_lane = lane_num;
          have_lk = 0; have_ln = 0;
          tgt = (ts_info == {LTSSM_POLL, POLL_ACTIVE}) ? TGT_PA : TGT_GEN;
        end
      end else if (active) begin
        if ((cyc - load_cyc) % P == 0)
          exp_ts_q.push_back('{cyc, ref_ts(m_info, m_mode, m_lane, have_lk, lk, have_ln, rl)});
        if (m_info[7:4] == LTSSM_CFG && mode == MODE_USP) begin
          cur_s1 = have_lk ? lk : 8'hF7;
          cur_s2 = have_ln ? rl : 8'hF7;
          if ((rcv_link_num_vld && rcv_link_num != cur_s1) ||
              (m_info[3:0] != CFG_LW_START && rcv_lane_num_vld && rcv_lane_num != cur_s2))
            exp_tsg_q.push_back(cyc);
          if (rcv_link_num_vld && rcv_link_num != cur_s1) begin
            have_lk = 1; lk = rcv_link_num;
          end
          if (m_info[3:0] != CFG_LW_START && rcv_lane_num_vld && rcv_lane_num != cur_s2) begin
            have_ln = 1; rl = rcv_lane_num;
          end
        end
      end
      // Enough once the target strobe count precedes this edge
      exp_enough = active && (cyc > load_cyc) && (((cyc - 1 - load_cyc) / P) >= tgt);
    end
  end

  // Monitor: compares DUT outputs against the queues on the falling edge
  initial begin : monitor
    exp_ts_t e;
    int      c;
    forever begin
      @(negedge clk);
      if (local_ts_valid) begin
        chk("strobe_expected", 128'(exp_ts_q.size() != 0), 128'(1));
        if (exp_ts_q.size() != 0) begin
          e = exp_ts_q.pop_front();
          chk("strobe_cycle", 128'(cyc), 128'(e.cyc));
          chk("ts_content", local_ts, e.ts);
        end
      end else if (exp_ts_q.size() != 0 && exp_ts_q[0].cyc <= cyc) begin
        e = exp_ts_q.pop_front();
        chk("strobe_missing", 128'(local_ts_valid), 128'(1));
      end
      if (ts_update_ack) begin
        chk("ack_expected", 128'(exp_ack_q.size() != 0), 128'(1));
        if (exp_ack_q.size() != 0) begin
          c = exp_ack_q.pop_front();
          chk("ack_cycle", 128'(cyc), 128'(c));
        end
      end else if (exp_ack_q.size() != 0 && exp_ack_q[0] <= cyc) begin
        c = exp_ack_q.pop_front();
        chk("ack_missing", 128'(ts_update_ack), 128'(1));
      end
      if (tsg_update_ack) begin
        chk("tsg_ack_expected", 128'(exp_tsg_q.size() != 0), 128'(1));
        if (exp_tsg_q.size() != 0) begin
          c = exp_tsg_q.pop_front();
          chk("tsg_ack_cycle", 128'(cyc), 128'(c));
        end
      end else if (exp_tsg_q.size() != 0 && exp_tsg_q[0] <= cyc) begin
        c = exp_tsg_q.pop_front();
        chk("tsg_ack_missing", 128'(tsg_update_ack), 128'(1));
      end
      chk("ts_sent_enough", 128'(ts_sent_enough), 128'(exp_enough));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [7:0] info);
    bit got;
    got = 0;
    ts_info = info;
    ts_update = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (ts_update_ack) begin got = 1; break; end
    end
    ts_update = 1'b0;
    chk("update_ack_seen", 128'(got), 128'(1));
  endtask

  task automatic wait_strobe(output bit got);
    got = 0;
    for (int i = 0; i < 4 * P; i++) begin
      step(1);
      if (local_ts_valid) begin got = 1; break; end
    end
    chk("strobe_within_bound", 128'(got), 128'(1));
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_valid"}, 128'(local_ts_valid), 128'(0));
    chk({nm, "_ack"}, 128'(ts_update_ack), 128'(0));
    chk({nm, "_tsg_ack"}, 128'(tsg_update_ack), 128'(0));
    chk({nm, "_enough"}, 128'(ts_sent_enough), 128'(0));
    chk({nm, "_ts"}, local_ts, 128'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got;
    step(3);
    chk_idle_outputs("reset");
    rst = 1'b0;
    step(2);

    // Polling.Active: 1024 TS1s; received numbers must be ignored in POLL
    mode = MODE_DSP;
    do_update({LTSSM_POLL, POLL_ACTIVE});
    wait_strobe(got);
    chk("poll_act_s6", 128'(local_ts[79:72]), 128'(8'h4A));
    for (int i = 0; i < TGT_PA * P + 4; i++) begin
      rcv_link_num_vld = 1'($urandom_range(0, 1));
      rcv_link_num     = 8'($urandom);
      step(1);
    end
    rcv_link_num_vld = 1'b0;
    chk("poll_act_enough", 128'(ts_sent_enough), 128'(1));

    // Reload to Polling.Configuration mid-period
    step($urandom_range(1, P - 2));
    do_update({LTSSM_POLL, POLL_CONFIG});
    chk("reload_clears_enough", 128'(ts_sent_enough), 128'(0));
    step(TGT_GEN * P + 5);
    chk("poll_cfg_enough", 128'(ts_sent_enough), 128'(1));

    // Config.Linkwidth.Start upstream: link number echo applies from next TS
    mode = MODE_USP;
    rcv_lane_num = 8'h07;
    rcv_lane_num_vld = 1'b1;
    do_update({LTSSM_CFG, CFG_LW_START});
    wait_strobe(got);
    step($urandom_range(2, P - 3));
    rcv_link_num = 8'h05;
    rcv_link_num_vld = 1'b1;
    step(2);
    chk("lw_start_cur_s1_pad", 128'(local_ts[119:112]), 128'(8'hF7));
    wait_strobe(got);
    chk("lw_start_next_s1", 128'(local_ts[119:112]), 128'(8'h05));
    chk("lw_start_s2_pad", 128'(local_ts[111:104]), 128'(8'hF7));
    step(2 * P);
    rcv_link_num_vld = 1'b0;
    rcv_lane_num_vld = 1'b0;

    // Config.Linkwidth.Accept downstream, lane 3
    mode = MODE_DSP;
    lane_num = 4'd3;
    do_update({LTSSM_CFG, CFG_LW_ACC});
    for (int i = 0; i < 3 * P + 2; i++) begin
      rcv_link_num_vld = 1'($urandom_range(0, 1));
      rcv_link_num     = 8'($urandom);
      step(1);
    end
    rcv_link_num_vld = 1'b0;
    chk("lw_acc_dsp_s1s2", 128'(local_ts[119:104]), 128'(16'h0103));

    // Upstream lane-number states with random received numbers
    mode = MODE_USP;
    do_update({LTSSM_CFG, CFG_LN_ACC});
    for (int k = 0; k < 8; k++) begin
      rcv_link_num     = 8'($urandom_range(0, 3));
      rcv_link_num_vld = 1'($urandom_range(0, 1));
      rcv_lane_num     = 8'($urandom_range(0, 3));
      rcv_lane_num_vld = 1'($urandom_range(0, 1));
      step($urandom_range(1, 2 * P));
    end
    do_update({LTSSM_CFG, CFG_COMPLETE});
    for (int k = 0; k < 6; k++) begin
      rcv_link_num     = 8'($urandom);
      rcv_lane_num     = 8'($urandom);
      rcv_link_num_vld = 1'($urandom_range(0, 1));
      rcv_lane_num_vld = 1'($urandom_range(0, 1));
      step($urandom_range(1, 2 * P));
    end
    rcv_link_num_vld = 1'b0;
    rcv_lane_num_vld = 1'b0;
    step(2 * P);

    // Stop and update together: one IDLE cycle, then reload from IDLE
    mode = MODE_DSP;
    ts_info = {LTSSM_CFG, CFG_LN_WAIT};
    ts_stop = 1'b1;
    ts_update = 1'b1;
    step(1);
    ts_stop = 1'b0;
    chk("stop_no_ack_yet", 128'(ts_update_ack), 128'(0));
    chk("stop_valid_low", 128'(local_ts_valid), 128'(0));
    do_update({LTSSM_CFG, CFG_LN_WAIT});
    step(2 * P + 3);

    // Unhandled state: acked, nothing emitted
    do_update(8'h50);
    step(2 * P);

    // Reset in the middle of sending
    do_update({LTSSM_POLL, POLL_ACTIVE});
    step($urandom_range(P + 1, 3 * P));
    rst = 1'b1;
    step(1);
    chk_idle_outputs("mid_reset");
    rst = 1'b0;
    step(3 * P);
    do_update({LTSSM_CFG, CFG_IDLE});
    step(2 * P + 2);

    step(2);
    chk("pending_strobes", 128'(exp_ts_q.size()), 128'(0));
    chk("pending_acks", 128'(exp_ack_q.size()), 128'(0));
    chk("pending_tsg_acks", 128'(exp_tsg_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
